// File: rtl/input_layer_buf.sv
// -----------------------------------------------------------------------------
// input_layer_buf
//   Input layer stage of the DNN datapath. Captures N_CH signed activations per
//   transfer into a DEPTH-entry vector FIFO and presents them to the first
//   hidden layer, so that stalls in layer 1 do not back up the stimulus source.
//   out_data reads as zero whenever no valid vector is presented.
//
// Optional feature (compile-time macro INPUT_LAYER_CLAMP_EN):
//   defined   -> each channel is saturated to [CLAMP_LO, CLAMP_HI] on write
//   undefined -> data is stored unmodified; CLAMP_LO/CLAMP_HI are unused
//
// Ports:
//   clk        system clock, all logic on rising edge
//   rst_n      asynchronous active-low reset (discards all stored vectors)
//   flush      synchronous clear of FIFO contents (wins over push/pop)
//   in_valid   source presents a vector
//   in_ready   a vector can be accepted this cycle (count < DEPTH)
//   in_data    packed signed activations, channel k at [k*DATA_W +: DATA_W]
//   out_valid  head vector is available (count != 0)
//   out_ready  downstream accepts the head vector
//   out_data   head vector, same packing; all zeros when out_valid = 0
//   count      current occupancy in vectors
//   overflow   sticky flag: in_valid seen while in_ready = 0 (cleared by rst_n)
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
//   high. ready never depends on valid on either side, so there is no
//   combinational loop; the source must hold valid/data until it sees ready.
// -----------------------------------------------------------------------------
module input_layer_buf #(
   parameter int N_CH     = 4,
   parameter int DATA_W   = 5,
   parameter int DEPTH    = 4,
   parameter int CLAMP_LO = -8,
   parameter int CLAMP_HI = 7
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             flush,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [N_CH*DATA_W-1:0]           in_data,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [N_CH*DATA_W-1:0]           out_data,
   output logic [$clog2(DEPTH+1)-1:0]       count,
   output logic                             overflow
);

   localparam int VEC_W = N_CH * DATA_W;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = $clog2(DEPTH);

   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   logic [VEC_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [VEC_W-1:0] wr_data;
   logic             push;
   logic             pop;

   // Explicit wrap compare keeps non-power-of-two depths correct.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_ONE;
   endfunction

   // Handshake decode. Both readiness terms come from registered count only,
   // so a full FIFO refuses input even while it is being drained.
   always_comb begin
      in_ready  = (count < DEPTH_C);
      out_valid = (count != '0);
      push      = in_valid & in_ready;
      pop       = out_valid & out_ready;
      out_data  = out_valid ? mem[rd_ptr] : '0;
   end

`ifdef INPUT_LAYER_CLAMP_EN
   localparam logic signed [DATA_W-1:0] LO_C = DATA_W'(CLAMP_LO);
   localparam logic signed [DATA_W-1:0] HI_C = DATA_W'(CLAMP_HI);

   logic signed [DATA_W-1:0] ch;

   // Per-channel saturation applied in front of the storage write port,
   // so clamping costs no extra cycle.
   always_comb begin
      wr_data = in_data;
      ch      = '0;
      for (int k = 0; k < N_CH; k++) begin
         ch = in_data[k*DATA_W +: DATA_W];
         if (ch < LO_C)
            wr_data[k*DATA_W +: DATA_W] = LO_C;
         else if (ch > HI_C)
            wr_data[k*DATA_W +: DATA_W] = HI_C;
      end
   end
`else
   always_comb begin
      wr_data = in_data;
   end
`endif

   // Storage has no reset; only the pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (push && !flush)
         mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= next_ptr(wr_ptr);
         if (pop)
            rd_ptr <= next_ptr(rd_ptr);
         if (push && !pop)
            count <= count + CNT_ONE;
         else if (pop && !push)
            count <= count - CNT_ONE;
      end
   end

   // Sticky drop indicator; flush deliberately leaves it alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         overflow <= 1'b0;
      else if (in_valid && !in_ready)
         overflow <= 1'b1;
   end

endmodule
